// File: rtl/costas_lock_ctrl.sv
// Costas loop lock controller: sequences pull-in, tracking and re-acquisition from
// integrate-and-dump epoch sums; every decision is registered one cycle after dump_valid.
module costas_lock_ctrl #(
  parameter int unsigned PULLIN_EPOCHS = 200,
  parameter int unsigned LOCK_CNT      = 20,
  parameter int unsigned LOSS_CNT      = 10,
  parameter int unsigned RATIO_SH      = 1,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        dump_valid,
  input  logic [31:0] sum_i,
  input  logic [31:0] sum_q,
  output logic        int_clear,
  output logic        filt_en,
  output logic        filt_wide,
  output logic        locked,
  output logic        fail,
  output logic [1:0]  state,
  output logic        data_valid,
  output logic        data_bit
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULL_IN = 2'd1,
    TRACK   = 2'd2,
    REACQ   = 2'd3
  } state_t;

  localparam int CMP_W = 33 + int'(RATIO_SH);
  localparam int EP_W  = $clog2(PULLIN_EPOCHS + 1);
  localparam int PS_W  = $clog2(LOCK_CNT + 1);
  localparam int LS_W  = $clog2(LOSS_CNT + 1);
  localparam int RT_W  = $clog2(MAX_RETRY + 2);

  localparam logic [EP_W-1:0] EP_MAX = EP_W'(PULLIN_EPOCHS);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(LOCK_CNT);
  localparam logic [LS_W-1:0] LS_MAX = LS_W'(LOSS_CNT);
  localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRY + 1);
  localparam logic [RT_W-1:0] RT_OK  = RT_W'(MAX_RETRY);

  // Most-negative input saturates so the magnitude always fits in 31 bits.
  function automatic logic [31:0] sat_abs(input logic [31:0] x);
    logic [31:0] r;
    if (x == 32'h8000_0000) r = 32'h7fff_ffff;
    else if (x[31])         r = ~x + 32'd1;
    else                    r = x;
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [EP_W-1:0]   epoch_q, epoch_d, epoch_inc;
  logic [PS_W-1:0]   pass_q, pass_d, pass_nxt;
  logic [LS_W-1:0]   loss_q, loss_d, loss_nxt;
  logic [RT_W-1:0]   retry_q, retry_d;
  logic              fail_q, fail_d;
  logic              int_clear_q, int_clear_d;
  logic              data_valid_q, data_valid_d;
  logic              data_bit_q, data_bit_d;

  logic [CMP_W-1:0]  mag_i, mag_q_sh;
  logic              pass_test, take;

  assign mag_i     = CMP_W'(sat_abs(sum_i));
  assign mag_q_sh  = CMP_W'(sat_abs(sum_q)) << RATIO_SH;
  assign pass_test = (mag_i >= mag_q_sh);
  // Integrators are being flushed during an int_clear cycle, so that dump is stale.
  assign take      = dump_valid && !int_clear_q;

  assign epoch_inc = (epoch_q == EP_MAX) ? epoch_q : epoch_q + EP_W'(1);
  assign pass_nxt  = !pass_test ? '0 : ((pass_q == PS_MAX) ? pass_q : pass_q + PS_W'(1));
  assign loss_nxt  = pass_test ? '0 : ((loss_q == LS_MAX) ? loss_q : loss_q + LS_W'(1));

  always_comb begin
    state_d      = state_q;
    epoch_d      = epoch_q;
    pass_d       = pass_q;
    loss_d       = loss_q;
    retry_d      = retry_q;
    fail_d       = fail_q;
    int_clear_d  = 1'b0;
    data_valid_d = 1'b0;
    data_bit_d   = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = PULL_IN;
            int_clear_d = 1'b1;
            fail_d      = 1'b0;
            epoch_d     = '0;
            pass_d      = '0;
            retry_d     = '0;
            loss_d      = '0;
          end
        end
        PULL_IN: begin
          if (take) begin
            epoch_d = epoch_inc;
            pass_d  = pass_nxt;
            if (pass_nxt == PS_MAX) begin
              state_d = TRACK;
              loss_d  = '0;
            end else if (epoch_inc == EP_MAX) begin
              state_d     = REACQ;
              int_clear_d = 1'b1;
              retry_d     = (retry_q == RT_MAX) ? retry_q : retry_q + RT_W'(1);
              epoch_d     = '0;
              pass_d      = '0;
            end
          end
        end
        REACQ: begin
          if (retry_q <= RT_OK) begin
            state_d = PULL_IN;
          end else begin
            state_d = IDLE;
            fail_d  = 1'b1;
          end
        end
        TRACK: begin
          if (take) begin
            data_valid_d = 1'b1;
            data_bit_d   = sum_i[31];
            loss_d       = loss_nxt;
            if (loss_nxt == LS_MAX) begin
              state_d = PULL_IN;
              epoch_d = '0;
              pass_d  = '0;
              loss_d  = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      epoch_q      <= '0;
      pass_q       <= '0;
      loss_q       <= '0;
      retry_q      <= '0;
      fail_q       <= 1'b0;
      int_clear_q  <= 1'b0;
      data_valid_q <= 1'b0;
      data_bit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      epoch_q      <= epoch_d;
      pass_q       <= pass_d;
      loss_q       <= loss_d;
      retry_q      <= retry_d;
      fail_q       <= fail_d;
      int_clear_q  <= int_clear_d;
      data_valid_q <= data_valid_d;
      data_bit_q   <= data_bit_d;
    end
  end

  assign state      = state_q;
  assign int_clear  = int_clear_q;
  assign filt_en    = (state_q == PULL_IN) || (state_q == TRACK);
  assign filt_wide  = (state_q == PULL_IN);
  assign locked     = (state_q == TRACK);
  assign fail       = fail_q;
  assign data_valid = data_valid_q;
  assign data_bit   = data_bit_q;

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Bench for costas_lock_ctrl: directed scenarios plus randomized traffic, each cycle
// compared with a behavioural model of the acquisition rules.
module tb_costas_lock_ctrl;

  localparam int PULLIN_EPOCHS = 200;
  localparam int LOCK_CNT      = 20;
  localparam int LOSS_CNT      = 10;
  localparam int RATIO_SH      = 1;
  localparam int MAX_RETRY     = 3;

  localparam int M_IDLE = 0, M_PULL = 1, M_TRACK = 2, M_REACQ = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, dump_valid = 1'b0;
  logic [31:0] sum_i = '0, sum_q = '0;
  logic        int_clear, filt_en, filt_wide, locked, fail, data_valid, data_bit;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  costas_lock_ctrl #(
    .PULLIN_EPOCHS(PULLIN_EPOCHS), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT),
    .RATIO_SH(RATIO_SH), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dump_valid(dump_valid),
    .sum_i(sum_i), .sum_q(sum_q), .int_clear(int_clear), .filt_en(filt_en),
    .filt_wide(filt_wide), .locked(locked), .fail(fail), .state(state),
    .data_valid(data_valid), .data_bit(data_bit)
  );

  always #5 clk = ~clk;

  // Reference model: phase of acquisition plus plain integer tallies.
  int m_st = M_IDLE, m_epoch = 0, m_pass = 0, m_loss = 0, m_retry = 0;
  bit m_fail = 0, m_clr = 0, m_dv = 0, m_db = 0, m_clr_prev, m_take, m_ok;

  function automatic bit lock_ok(input logic [31:0] i, input logic [31:0] q);
    longint ai, aq;
    ai = longint'($signed(i));
    aq = longint'($signed(q));
    if (ai < 0) ai = -ai;
    if (aq < 0) aq = -aq;
    if (ai > 64'sd2147483647) ai = 64'sd2147483647;
    if (aq > 64'sd2147483647) aq = 64'sd2147483647;
    return ai >= aq * (longint'(1) << RATIO_SH);
  endfunction

  always @(posedge clk) begin
    m_clr_prev = m_clr;
    m_clr = 0; m_dv = 0; m_db = 0;
    m_take = dump_valid && !m_clr_prev;
    m_ok = lock_ok(sum_i, sum_q);
    if (rst) begin
      m_st = M_IDLE; m_epoch = 0; m_pass = 0; m_loss = 0; m_retry = 0; m_fail = 0;
    end else if (stop) begin
      m_st = M_IDLE;
    end else if (m_st == M_IDLE) begin
      if (start) begin
        m_st = M_PULL; m_clr = 1; m_fail = 0; m_epoch = 0; m_pass = 0; m_retry = 0;
      end
    end else if (m_st == M_PULL) begin
      if (m_take) begin
        m_epoch = (m_epoch < PULLIN_EPOCHS) ? m_epoch + 1 : m_epoch;
        m_pass  = m_ok ? m_pass + 1 : 0;
        if (m_pass >= LOCK_CNT) begin
          m_st = M_TRACK; m_loss = 0;
        end else if (m_epoch >= PULLIN_EPOCHS) begin
          m_st = M_REACQ; m_clr = 1; m_retry++; m_epoch = 0; m_pass = 0;
        end
      end
    end else if (m_st == M_REACQ) begin
      if (m_retry <= MAX_RETRY) m_st = M_PULL;
      else begin m_st = M_IDLE; m_fail = 1; end
    end else begin
      if (m_take) begin
        m_dv = 1;
        m_db = ($signed(sum_i) < 0);
        m_loss = m_ok ? 0 : m_loss + 1;
        if (m_loss >= LOSS_CNT) begin m_st = M_PULL; m_epoch = 0; m_pass = 0; end
      end
    end
  end

  logic [8:0] dut_vec, mdl_vec;
  logic [1:0] m_st2;
  assign m_st2   = m_st[1:0];
  assign dut_vec = {state, int_clear, filt_en, filt_wide, locked, fail, data_valid, data_bit};
  assign mdl_vec = {m_st2, m_clr, (m_st == M_PULL) || (m_st == M_TRACK), m_st == M_PULL,
                    m_st == M_TRACK, m_fail, m_dv, m_db};

  // Applies one cycle of inputs at a falling edge and returns at the next one.
  task automatic drive(input bit st, input bit sp, input bit dv,
                       input logic [31:0] si, input logic [31:0] sq);
    start = st; stop = sp; dump_valid = dv; sum_i = si; sum_q = sq;
    @(negedge clk);
  endtask

  task automatic go_track();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < LOCK_CNT; k++) drive(0, 0, 1, 32'd1000, 32'd100);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      checks++;
      if (dut_vec !== 9'd0) begin
        errors++;
        $display("FAIL reset_outputs k=%0d dut=%b required=%b", k, dut_vec, 9'd0);
      end
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_acquire();
    int clr_cnt = 0;
    drive(1, 0, 0, 0, 0);
    checks++;
    if (state !== 2'd1 || int_clear !== 1'b1 || filt_wide !== 1'b1) begin
      errors++;
      $display("FAIL acq_entry state=%0d int_clear=%b filt_wide=%b required 1,1,1", state, int_clear, filt_wide);
    end
    clr_cnt += int_clear;
    // Dump during the int_clear cycle must not count toward lock.
    drive(0, 0, 1, 32'd1000, 32'd100);
    clr_cnt += int_clear;
    for (int k = 0; k < LOCK_CNT; k++) begin
      drive(0, 0, 1, 32'd1000, 32'd100);
      clr_cnt += int_clear;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL acq_cycle k=%0d dut=%b model=%b", k, dut_vec, mdl_vec);
      end
      if (k == LOCK_CNT - 2) begin
        checks++;
        if (state !== 2'd1) begin
          errors++;
          $display("FAIL acq_early_lock state=%0d required=1", state);
        end
      end
    end
    checks++;
    if (state !== 2'd2 || locked !== 1'b1 || filt_en !== 1'b1 || filt_wide !== 1'b0 || clr_cnt != 1) begin
      errors++;
      $display("FAIL acq_locked state=%0d locked=%b filt=%b%b clr_pulses=%0d required 2,1,10,1",
               state, locked, filt_en, filt_wide, clr_cnt);
    end
  endtask

  task automatic test_data_bits();
    drive(0, 0, 1, 32'hffff_ec78, 32'd0);  // -5000
    checks++;
    if (data_valid !== 1'b1 || data_bit !== 1'b1) begin
      errors++;
      $display("FAIL data_neg dv=%b bit=%b required 1,1", data_valid, data_bit);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL data_pulse_width dv=%b required 0", data_valid);
    end
    drive(0, 0, 1, 32'd5000, 32'd0);
    checks++;
    if (data_valid !== 1'b1 || data_bit !== 1'b0) begin
      errors++;
      $display("FAIL data_pos dv=%b bit=%b required 1,0", data_valid, data_bit);
    end
  endtask

  task automatic test_loss();
    for (int k = 0; k < LOSS_CNT - 1; k++) drive(0, 0, 1, 32'd100, 32'd100);
    drive(0, 0, 1, 32'd1000, 32'd100);
    for (int k = 0; k < LOSS_CNT - 1; k++) drive(0, 0, 1, 32'd100, 32'd100);
    checks++;
    if (state !== 2'd2 || locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_reset_by_pass state=%0d locked=%b required 2,1", state, locked);
    end
    drive(0, 0, 1, 32'd100, 32'd100);
    checks++;
    if (state !== 2'd1 || locked !== 1'b0 || data_valid !== 1'b1 || int_clear !== 1'b0) begin
      errors++;
      $display("FAIL loss_exit state=%0d locked=%b dv=%b clr=%b required 1,0,1,0",
               state, locked, data_valid, int_clear);
    end
    drive(0, 1, 0, 0, 0);
  endtask

  task automatic test_timeout();
    int clr_cnt = 0, reacq_cnt = 0, cyc = 0;
    drive(1, 0, 0, 0, 0);
    clr_cnt += int_clear;
    while (state != 2'd0 && cyc < 3000) begin
      drive(0, 0, 1, 32'd0, 32'd1000);
      cyc++;
      clr_cnt += int_clear;
      if (state == 2'd3) reacq_cnt++;
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL timeout_cycle c=%0d dut=%b model=%b", cyc, dut_vec, mdl_vec);
      end
    end
    checks++;
    if (state !== 2'd0 || fail !== 1'b1 || reacq_cnt != MAX_RETRY + 1 || clr_cnt != MAX_RETRY + 2) begin
      errors++;
      $display("FAIL timeout_end state=%0d fail=%b reacq=%0d clr=%0d cycles=%0d required 0,1,%0d,%0d",
               state, fail, reacq_cnt, clr_cnt, cyc, MAX_RETRY + 1, MAX_RETRY + 2);
    end
    drive(0, 0, 1, 32'd5000, 32'd0);
    checks++;
    if (fail !== 1'b1 || filt_en !== 1'b0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL fail_sticky fail=%b filt_en=%b dv=%b required 1,0,0", fail, filt_en, data_valid);
    end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 0);
    checks++;
    if (fail !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_fail fail=%b required 0", fail);
    end
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < LOCK_CNT; k++) drive(0, 0, 1, 32'h8000_0000, 32'h2000_0000);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL sat_pass state=%0d required 2", state);
    end
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < LOCK_CNT - 1; k++) drive(0, 0, 1, 32'd1000, 32'd100);
    drive(0, 0, 1, 32'h8000_0000, 32'h4000_0000);
    drive(0, 0, 1, 32'd1000, 32'd100);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL sat_fail state=%0d required 1", state);
    end
    drive(0, 1, 0, 0, 0);
  endtask

  task automatic test_stop_rst();
    go_track();
    drive(0, 1, 1, 32'hffff_ec78, 32'd0);
    checks++;
    if (dut_vec !== 9'd0) begin
      errors++;
      $display("FAIL stop_in_track dut=%b required=%b", dut_vec, 9'd0);
    end
    drive(1, 1, 0, 0, 0);
    checks++;
    if (state !== 2'd0 || int_clear !== 1'b0) begin
      errors++;
      $display("FAIL stop_over_start state=%0d clr=%b required 0,0", state, int_clear);
    end
    go_track();
    rst = 1'b1;
    drive(1, 0, 1, 32'hffff_ec78, 32'd0);
    rst = 1'b0;
    checks++;
    if (dut_vec !== 9'd0) begin
      errors++;
      $display("FAIL rst_in_track dut=%b required=%b", dut_vec, 9'd0);
    end
  endtask

  task automatic test_random();
    int pct = 100;
    bit want, neg_i, neg_q;
    logic [31:0] mi, mq, si, sq;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 40;
          2: pct = 90;
          default: pct = 100;
        endcase
      end
      want = ($urandom_range(0, 99) < pct);
      mq = 32'($urandom_range(0, 100000));
      if (want) mi = (mq << RATIO_SH) + 32'($urandom_range(0, 3));
      else mi = (mq << RATIO_SH) - 32'($urandom_range(1, 3));
      neg_i = 1'($urandom); neg_q = 1'($urandom);
      si = neg_i ? (~mi + 32'd1) : mi;
      sq = neg_q ? (~mq + 32'd1) : mq;
      if ($urandom_range(0, 31) == 0) begin
        si = 32'h8000_0000;
        sq = ($urandom_range(0, 1) == 1) ? 32'h4000_0000 : 32'h3fff_ffff;
      end
      rst = ($urandom_range(0, 511) == 0);
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0,
            $urandom_range(0, 3) != 0, si, sq);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++;
        $display("FAIL random c=%0d dut=%b model=%b", c, dut_vec, mdl_vec);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_acquire();
    test_data_bits();
    test_loss();
    test_timeout();
    test_saturation();
    test_stop_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/costas_lock_ctrl.md
COSTAS_LOCK_CTRL -- requirements
Module: costas_lock_ctrl

Interface
REQ-001 The block SHALL have parameter PULLIN_EPOCHS, default 200: max dump epochs allowed in PULL_IN before timeout.
REQ-002 The block SHALL have parameter LOCK_CNT, default 20: consecutive passing epochs required to declare lock.
REQ-003 The block SHALL have parameter LOSS_CNT, default 10: consecutive failing epochs in TRACK that declare loss of lock.
REQ-004 The block SHALL have parameter RATIO_SH, default 1: the lock test passes when |I| >= (|Q| << RATIO_SH).
REQ-005 The block SHALL have parameter MAX_RETRY, default 3: number of PULL_IN timeouts tolerated before failing.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: begins acquisition when sampled high in IDLE.
REQ-009 The block SHALL have port stop, input, 1 bit: forces IDLE from any state.
REQ-010 The block SHALL have port dump_valid, input, 1 bit: single-cycle strobe that marks sum_i and sum_q as valid integrate-and-dump results.
REQ-011 The block SHALL have ports sum_i and sum_q, input, 32 bits each, signed: the I and Q epoch sums.
REQ-012 The block SHALL have port int_clear, output, 1 bit: single-cycle pulse that restarts both integrators.
REQ-013 The block SHALL have ports filt_en and filt_wide, output, 1 bit each: filt_en enables the loop filter; filt_wide selects the wide pull-in gain.
REQ-014 The block SHALL have ports locked and fail, output, 1 bit each: locked is the lock status; fail is a sticky acquisition-failure flag.
REQ-015 The block SHALL have port state, output, 2 bits, with encoding IDLE=0, PULL_IN=1, TRACK=2, REACQ=3.
REQ-016 The block SHALL have ports data_valid and data_bit, output, 1 bit each: data_valid is a single-cycle pulse qualifying data_bit, the demodulated bit.

Function
REQ-017 The block SHALL compute |x| for each sum with saturation: |-2^31| = 2^31-1.
REQ-018 The block SHALL evaluate the lock test in at least 33+RATIO_SH bits, so the shifted |Q| never overflows.
REQ-019 The block SHALL, in IDLE, drive filt_en=0, filt_wide=0, locked=0 and ignore dump_valid.
REQ-020 When start=1 in IDLE, the block SHALL enter PULL_IN on the next cycle, pulse int_clear for that cycle, clear fail, and zero the epoch, pass and retry counters.
REQ-021 The block SHALL, in PULL_IN, drive filt_en=1 and filt_wide=1.
REQ-022 In PULL_IN, each dump_valid SHALL increment the epoch counter; a passing test increments the pass counter and a failing test zeroes it.
REQ-023 When the pass counter reaches LOCK_CNT in PULL_IN, the block SHALL enter TRACK, with locked=1 from the first TRACK cycle.
REQ-024 When the epoch counter reaches PULLIN_EPOCHS without lock in PULL_IN, the block SHALL enter REACQ.
REQ-025 If the lock and timeout conditions occur on the same epoch, lock SHALL win.
REQ-026 The block SHALL, in REACQ (one cycle), pulse int_clear, increment the retry counter and zero the epoch and pass counters.
REQ-027 On leaving REACQ, the block SHALL go to PULL_IN if retry <= MAX_RETRY, else to IDLE with fail=1.
REQ-028 The block SHALL, in TRACK, drive filt_en=1, filt_wide=0 and locked=1.
REQ-029 In TRACK, each dump_valid SHALL produce data_valid=1 one cycle later, with data_bit=1 when sum_i < 0, else 0.
REQ-030 In TRACK, a failing test SHALL increment the fail counter and a passing test SHALL zero it.
REQ-031 When the fail counter reaches LOSS_CNT in TRACK, the block SHALL deassert locked and enter PULL_IN with the epoch and pass counters zeroed, without an int_clear pulse and without changing the retry count.
REQ-032 The data_valid pulse of the loss epoch SHALL still be issued.
REQ-033 All state decisions SHALL be registered, with latency of one cycle from dump_valid.
REQ-034 A dump_valid arriving during the int_clear cycle SHALL be ignored.
REQ-035 When stop=1, the block SHALL enter IDLE next cycle from any state, with no int_clear pulse and no data_valid pulse.
REQ-036 stop SHALL take priority over start, over dump_valid and over every transition.
REQ-037 Counters SHALL saturate at their terminal values and never wrap.

Reset
REQ-038 While rst=1, the block SHALL hold state=IDLE and drive every output and counter to 0, fail included.
REQ-039 rst SHALL override start, stop and dump_valid.
REQ-040 An assertion of rst mid-operation SHALL abort the block to IDLE on the next cycle, with no int_clear pulse.

Verification
REQ-041 Start, then 20 dumps with I=1000, Q=100 -> state=TRACK and locked=1 one cycle after the 20th dump_valid; int_clear pulsed once at entry to PULL_IN.
REQ-042 In TRACK, a dump with I=-5000, Q=0 -> data_valid pulse one cycle later with data_bit=1; a dump with I=5000 -> data_bit=0.
REQ-043 In TRACK, 10 dumps with I=100, Q=100 -> locked falls and state=PULL_IN after the 10th; 9 failing dumps then 1 passing dump -> stays in TRACK.
REQ-044 Constant I=0, Q=1000 -> four timeouts of 200 epochs each, four REACQ int_clear pulses, then IDLE with fail=1.
REQ-045 I=-2^31, Q=2^30 with RATIO_SH=1 -> test fails, |I| saturated to 2^31-1 < 2^31; I=-2^31, Q=2^29 -> test passes.
REQ-046 stop or rst asserted together with dump_valid in TRACK -> IDLE next cycle, no data_valid pulse, all outputs 0.
